adder_resp_chk: RTL and testbench
=================================

# adder_resp_chk

Synthesizable response checker that sits at the receiving end of the adder verification path. The stimulus side drives every operand pair into the ripple-carry adder; this block consumes each `{a, b, sum, cout}` result over a valid/ready handshake and recomputes the expected result. It counts mismatches, latches the first failing vector, and reports done/pass after the full exhaustive operand space has been seen. It replaces `$monitor` eyeballing and is usable both in simulation and on-board self-test.

## Interface
- `WIDTH`, default 4: operand width of the adder under test.
- `NUM_VEC`, default 2**(2*WIDTH): number of vectors that completes a run (256 at default).
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous restart to IDLE, all counters zeroed.
- `in_valid` in 1: result vector present.
- `in_ready` out 1: checker can accept.
- `in_a`, `in_b` in WIDTH: operands applied to the adder.
- `in_sum` in WIDTH, `in_cout` in 1: adder response.
- `vec_count` out 2*WIDTH+1: vectors checked.
- `err_count` out 2*WIDTH+1: mismatching vectors; saturates at all-ones.
- `first_err_valid` out 1: a mismatch has been latched.
- `first_err_a`, `first_err_b` out WIDTH: operands of the first mismatch.
- `done` out 1: NUM_VEC vectors checked.
- `pass` out 1: `done` and `err_count == 0`.

## Operation
- Reset values: `in_ready`=1; `done`, `pass`, and `first_err_valid` are 0; all counts and `first_err_*` are 0; FSM in IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on the first accepted vector.
  - RUN→DONE on the edge where `vec_count` reaches NUM_VEC.
  - DONE→IDLE only on `clear` or reset.
- Accept condition: `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and RUN while the accepted-vector count is below NUM_VEC. It is 0 from the edge after the NUM_VEC-th acceptance, and stays 0 in DONE.
- Stage 1 registers the accepted vector. Stage 2 compares `{in_cout, in_sum}` against `in_a + in_b`, computed at WIDTH+1 bits zero-extended with no truncation.
- On each stage-2 result:
  - `vec_count` increments.
  - On a mismatch, `err_count` increments, saturating at all-ones.
  - If `first_err_valid` is 0, `first_err_a` and `first_err_b` are latched and `first_err_valid` is set. Later errors never overwrite the latched vector.
- `pass` is combinational from the registered `done` and `err_count`.
- `clear` overrides everything in the same cycle. Pipeline contents are discarded, and a vector offered in the same cycle as `clear` is not accepted and not counted.
- Reset asserted mid-run returns all outputs to reset values immediately (asynchronous reset).

## Timing
- Acceptance at edge N: the counters and `first_err_*` update at edge N+2 (2-cycle latency).
- `done` rises at the same edge that `vec_count` becomes NUM_VEC, which is two edges after the last acceptance.
- Full throughput: one vector per cycle when `in_valid` is held high. Gaps in `in_valid` insert bubbles with no effect on results.
- `in_valid` may drop without a transfer; inputs are sampled only on acceptance.

## Configuration
- `ADDER_CHK_ORDER_EN` defined: the checker also enforces exhaustive ordering. The expected vector index is `{a, b}` == number of vectors accepted so far (mod NUM_VEC). An out-of-order vector counts as a mismatch and is latched as first error, even if its sum is arithmetically correct.
- Not defined: vectors are accepted in any order, and only the arithmetic is checked. There is no duplicate or coverage checking.

## Structure
- Package `adder_chk_pkg` holds:
  - the FSM state enum (`CHK_IDLE`, `CHK_RUN`, `CHK_DONE`);
  - the default `WIDTH` constant;
  - the vector struct `{a, b, sum, cout}`.
- One sub-module, `adder_ref_model`: combinational golden `a + b` → `{cout, sum}`, instantiated in stage 2. Everything else stays in the top.

## Test plan
- Exhaustive in-order correct stream, `in_valid` held high for 256 cycles → `done` two cycles after the last acceptance, `vec_count`=256, `err_count`=0, `pass`=1, `in_ready`=0.
- Same stream with the a=3, b=5 response corrupted to sum=0000, cout=0, plus a second corruption at a=15, b=15 → `err_count`=2, `first_err_a`=3, `first_err_b`=5, `pass`=0.
- Random `in_valid` gaps (about 50% duty) over the full stream → identical final results to the back-to-back case; no vector is counted twice.
- `clear` pulsed while `vec_count`=100 and `in_valid`=1 → next cycle all counts are 0 and the state is IDLE. Rerunning 256 vectors gives `pass`=1.
- `rst_n` low for 1 cycle mid-run → outputs are at reset values immediately, and `in_ready`=1.
- With `ADDER_CHK_ORDER_EN`, vector a=0, b=2 sent second (skipping a=0, b=1), with correct sums → `err_count`≥1, `first_err_a`=0, `first_err_b`=2. Without the macro, the same stream → `err_count`=0.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared types and defaults for the adder response checker
package adder_chk_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      CHK_IDLE,
      CHK_RUN,
      CHK_DONE
   } chk_state_t;

   typedef struct packed {
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      logic [DEF_WIDTH-1:0] sum;
      logic                 cout;
   } chk_vec_t;

endpackage

// File: rtl/adder_ref_model.sv
// rtl/adder_ref_model.sv - combinational golden a + b for the response checker
module adder_ref_model #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_resp_chk.sv
// rtl/adder_resp_chk.sv - adder result checker; ADDER_CHK_ORDER_EN adds exhaustive-order checking
module adder_resp_chk
   import adder_chk_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_VEC = 2 ** (2 * WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [WIDTH-1:0]   in_sum,
   input  logic               in_cout,
   output logic [2*WIDTH:0]   vec_count,
   output logic [2*WIDTH:0]   err_count,
   output logic               first_err_valid,
   output logic [WIDTH-1:0]   first_err_a,
   output logic [WIDTH-1:0]   first_err_b,
   output logic               done,
   output logic               pass
);

   localparam int            CW        = 2 * WIDTH + 1;
   localparam logic [CW-1:0] NUM_VEC_C = CW'(NUM_VEC);
   localparam logic [CW-1:0] LAST_VEC  = CW'(NUM_VEC - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   chk_state_t       state;
   logic [CW-1:0]    acc_count;
   logic             accept;
   logic             order_bad;
   logic             s1_valid, s1_order_bad, s1_cout;
   logic [WIDTH-1:0] s1_a, s1_b, s1_sum;
   logic             s2_valid, s2_order_bad, s2_cout;
   logic [WIDTH-1:0] s2_a, s2_b, s2_sum;
   logic [WIDTH-1:0] ref_sum;
   logic             ref_cout;
   logic             mismatch;

   assign in_ready = (state != CHK_DONE) && (acc_count < NUM_VEC_C);
   assign accept   = in_valid && in_ready && !clear;

`ifdef ADDER_CHK_ORDER_EN
   // Exhaustive order: the n-th accepted vector must carry operands {a, b} == n.
   assign order_bad = ({in_a, in_b} != acc_count[2*WIDTH-1:0]);
`else
   assign order_bad = 1'b0;
`endif

   adder_ref_model #(.WIDTH(WIDTH)) u_ref (
      .a    (s2_a),
      .b    (s2_b),
      .sum  (ref_sum),
      .cout (ref_cout)
   );

   assign mismatch = s2_order_bad || ({s2_cout, s2_sum} != {ref_cout, ref_sum});
   assign pass     = done && (err_count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= CHK_IDLE;
         acc_count       <= '0;
         s1_valid        <= 1'b0;
         s1_order_bad    <= 1'b0;
         s1_a            <= '0;
         s1_b            <= '0;
         s1_sum          <= '0;
         s1_cout         <= 1'b0;
         s2_valid        <= 1'b0;
         s2_order_bad    <= 1'b0;
         s2_a            <= '0;
         s2_b            <= '0;
         s2_sum          <= '0;
         s2_cout         <= 1'b0;
         vec_count       <= '0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         done            <= 1'b0;
      end else if (clear) begin
         // Restart drops whatever is in flight; stage data is don't-care once invalid.
         state           <= CHK_IDLE;
         acc_count       <= '0;
         s1_valid        <= 1'b0;
         s2_valid        <= 1'b0;
         vec_count       <= '0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_a     <= '0;
         first_err_b     <= '0;
         done            <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            acc_count    <= acc_count + CNT_ONE;
            s1_a         <= in_a;
            s1_b         <= in_b;
            s1_sum       <= in_sum;
            s1_cout      <= in_cout;
            s1_order_bad <= order_bad;
            if (state == CHK_IDLE)
               state <= CHK_RUN;
         end

         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_a         <= s1_a;
            s2_b         <= s1_b;
            s2_sum       <= s1_sum;
            s2_cout      <= s1_cout;
            s2_order_bad <= s1_order_bad;
         end

         if (s2_valid) begin
            vec_count <= vec_count + CNT_ONE;
            if (mismatch && (err_count != CNT_MAX))
               err_count <= err_count + CNT_ONE;
            if (mismatch && !first_err_valid) begin
               first_err_valid <= 1'b1;
               first_err_a     <= s2_a;
               first_err_b     <= s2_b;
            end
            if (vec_count == LAST_VEC) begin
               state <= CHK_DONE;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_resp_chk.sv
// tb/tb_adder_resp_chk.sv - scoreboard bench for adder_resp_chk with random gaps and corruptions
module tb_adder_resp_chk;
   import adder_chk_pkg::*;

   localparam int W  = DEF_WIDTH;
   localparam int N  = 1 << (2 * W);
   localparam int CW = 2 * W + 1;
   localparam int P  = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0, in_b = '0, in_sum = '0;
   logic          in_cout = 1'b0;
   logic [CW-1:0] vec_count, err_count;
   logic          first_err_valid;
   logic [W-1:0]  first_err_a, first_err_b;
   logic          done, pass;

   adder_resp_chk #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear           (clear),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_sum          (in_sum),
      .in_cout         (in_cout),
      .vec_count       (vec_count),
      .err_count       (err_count),
      .first_err_valid (first_err_valid),
      .first_err_a     (first_err_a),
      .first_err_b     (first_err_b),
      .done            (done),
      .pass            (pass)
   );

   always #(P/2) clk = ~clk;

   typedef struct {
      int  vc;
      int  err;
      bit  fev;
      int  fa;
      int  fb;
      bit  dn;
      time t;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   m_acc, m_vc, m_err, m_fa, m_fb;
   bit   m_fev;
   int   prev_vc = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic fail_now(input string name, input string detail);
      n_checks++;
      $display("FAIL %s: %s", name, detail);
   endtask

   function automatic void model_reset();
      m_acc = 0; m_vc = 0; m_err = 0; m_fev = 0; m_fa = 0; m_fb = 0;
      sb.delete();
   endfunction

   // Reference: the response is right when cout:sum equals a+b as plain integers.
   function automatic void model_accept(input chk_vec_t v);
      int got;
      bit bad;
      got = (int'(v.cout) << W) + int'(v.sum);
      bad = (got != int'(v.a) + int'(v.b));
`ifdef ADDER_CHK_ORDER_EN
      if (((int'(v.a) << W) + int'(v.b)) != (m_acc % N)) bad = 1'b1;
`endif
      m_acc++;
      m_vc++;
      if (bad && m_err < (1 << CW) - 1) m_err++;
      if (bad && !m_fev) begin
         m_fev = 1'b1; m_fa = int'(v.a); m_fb = int'(v.b);
      end
      sb.push_back('{m_vc, m_err, m_fev, m_fa, m_fb, (m_vc == N), $time});
   endfunction

   function automatic chk_vec_t mk_vec(input int idx, input bit corrupt);
      chk_vec_t v;
      int s;
      v.a = W'(idx >> W);
      v.b = W'(idx);
      s = int'(v.a) + int'(v.b);
      v.sum = W'(s);
      v.cout = s[W];
      if (corrupt) begin
         v.sum = '0; v.cout = 1'b0;
      end
      return v;
   endfunction

   task automatic drive_vec(input chk_vec_t v);
      bit acc;
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = v.a; in_b = v.b; in_sum = v.sum; in_cout = v.cout;
         acc = in_ready;
         @(posedge clk);
         if (acc) begin
            model_accept(v);
            return;
         end
      end
      fail_now("accept_timeout", "vector never accepted");
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_a = W'($urandom); in_b = W'($urandom); in_sum = W'($urandom); in_cout = 1'($urandom);
   endtask

   task automatic run_stream(input bit gaps, input bit corrupt);
      for (int i = 0; i < N; i++) begin
         if (gaps)
            for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) idle();
         drive_vec(mk_vec(i, corrupt && (i == 3 * 16 + 5 || i == N - 1)));
      end
      idle();
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
      if (sb.size() != 0) fail_now("drain_timeout", "expected results never reported");
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1 model_reset();
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic final_chk(input int vc, input int err, input bit dn, input bit ps, input bit rdy);
      chk("final_vec_count", vec_count, vc);
      chk("final_err_count", err_count, err);
      chk("final_done", done, dn);
      chk("final_pass", pass, ps);
      chk("final_in_ready", in_ready, rdy);
   endtask

   task automatic reset_val_chk(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_vec_count"}, vec_count, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_first_err_valid"}, first_err_valid, 0);
      chk({tag, "_first_err_a"}, first_err_a, 0);
      chk({tag, "_first_err_b"}, first_err_b, 0);
   endtask

   // Monitor: each vec_count step is one stage-2 result, two edges after its acceptance.
   always @(negedge clk) begin
      if (int'(vec_count) != prev_vc) begin
         if (vec_count != '0) begin
            if (sb.size() == 0) begin
               fail_now("unexpected_count", $sformatf("vec_count %0d with nothing pending", vec_count));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("mon_vec_count", vec_count, e.vc);
               chk("mon_err_count", err_count, e.err);
               chk("mon_first_err_valid", first_err_valid, e.fev);
               chk("mon_first_err_a", first_err_a, e.fa);
               chk("mon_first_err_b", first_err_b, e.fb);
               chk("mon_done", done, e.dn);
               chk("mon_pass", pass, e.dn && e.err == 0);
               chk("mon_latency", $time - e.t, 2 * P + P / 2);
            end
         end
         prev_vc = int'(vec_count);
      end
   end

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      reset_val_chk("reset");
      rst_n = 1'b1;

      // Back-to-back exhaustive stream.
      run_stream(1'b0, 1'b0);
      drain();
      final_chk(N, 0, 1'b1, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1;
      end
      idle();
      idle();
      chk("after_done_vec_count", vec_count, N);

      // Two corrupted responses; the first one must stay latched.
      do_clear();
      run_stream(1'b0, 1'b1);
      drain();
      final_chk(N, 2, 1'b1, 1'b0, 1'b0);
      chk("corrupt_first_err_valid", first_err_valid, 1);
      chk("corrupt_first_err_a", first_err_a, 3);
      chk("corrupt_first_err_b", first_err_b, 5);

      // Random valid gaps must give the same result as back-to-back.
      do_clear();
      run_stream(1'b1, 1'b0);
      drain();
      final_chk(N, 0, 1'b1, 1'b1, 1'b0);

      // Clear while vec_count is 100 with a vector offered in the same cycle.
      do_clear();
      for (int i = 0; i < 102; i++) drive_vec(mk_vec(i, 1'b0));
      @(negedge clk);
      chk("pre_clear_vec_count", vec_count, 100);
      clear = 1'b1;
      in_valid = 1'b1; in_a = W'(102 >> W); in_b = W'(102); in_sum = 4'h6; in_cout = 1'b0;
      @(posedge clk);
      #1 model_reset();
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      reset_val_chk("clear");
      run_stream(1'b0, 1'b0);
      drain();
      final_chk(N, 0, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset mid-run.
      do_clear();
      for (int i = 0; i < 50; i++) drive_vec(mk_vec(i, i == 7));
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      reset_val_chk("midrun_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Skip a=0,b=1: only an ordering error, the sums are correct.
      do_clear();
      drive_vec(mk_vec(0, 1'b0));
      drive_vec(mk_vec(2, 1'b0));
      idle();
      drain();
`ifdef ADDER_CHK_ORDER_EN
      chk("order_err_nonzero", err_count >= 1, 1);
      chk("order_first_err_a", first_err_a, 0);
      chk("order_first_err_b", first_err_b, 2);
`else
      chk("order_err_count", err_count, 0);
`endif
      chk("order_vec_count", vec_count, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
